// File: rtl/opsum_drain_pkg.sv
// opsum_drain_pkg: shared types and constants for the opsum_fifo drain controller.
//   state_t    - drain FSM states
//   POP_16/32  - fifo_pop_mod encodings
//   WMASK_*    - GLB byte-enable masks for a full word / low half-word
//   PSUM_W     - width of one output partial sum
package opsum_drain_pkg;

    localparam int unsigned PSUM_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POP       = 3'd1,
        WAIT_DATA = 3'd2,
        WRITE     = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic POP_16 = 1'b0;
    localparam logic POP_32 = 1'b1;

    localparam logic [3:0] WMASK_FULL = 4'b1111;
    localparam logic [3:0] WMASK_LOW  = 4'b0011;

endpackage

// File: rtl/opsum_drain.sv
// opsum_drain: drains psum_cnt 16-bit psums from opsum_fifo, packs them in
// pairs into 32-bit words and writes them to the GLB at consecutive word
// addresses starting at base_addr. A trailing odd psum is written alone with
// a low half-word mask.
// Ports:
//   clk, rst_n                     - clock, async active-low reset
//   start, base_addr, psum_cnt     - drain request and its parameters
//   busy, done                     - status / one-cycle completion pulse
//   fifo_empty, fifo_ge2           - FIFO occupancy flags
//   fifo_pop_en, fifo_pop_mod      - pop request (mod 1 = 32-bit burst pop)
//   fifo_pop_data                  - pop data, valid the cycle after the pop
//   glb_we, glb_addr, glb_wdata,
//   glb_wmask, glb_ready           - GLB write port with ready handshake
module opsum_drain
    import opsum_drain_pkg::*;
#(
    parameter int unsigned DATA_W = PSUM_W,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    psum_cnt,
    output logic                busy,
    output logic                done,
    input  logic                fifo_empty,
    input  logic                fifo_ge2,
    output logic                fifo_pop_en,
    output logic                fifo_pop_mod,
    input  logic [2*DATA_W-1:0] fifo_pop_data,
    output logic                glb_we,
    output logic [ADDR_W-1:0]   glb_addr,
    output logic [2*DATA_W-1:0] glb_wdata,
    output logic [3:0]          glb_wmask,
    input  logic                glb_ready
);

    state_t              state;
    logic [CNT_W-1:0]    rem;
    logic [ADDR_W-1:0]   addr;
    logic [2*DATA_W-1:0] wbuf;
    logic                pair;

    logic                can_pair;
    logic                can_single;
    logic [CNT_W-1:0]    rem_next;

    // A burst pop needs two entries present; fifo_empty alone is not enough.
    always_comb begin
        can_pair   = (rem >= CNT_W'(2)) && fifo_ge2;
        can_single = (rem == CNT_W'(1)) && !fifo_empty;
        rem_next   = pair ? (rem - CNT_W'(2)) : (rem - CNT_W'(1));
    end

    // The pop must reach the FIFO in the POP cycle so data lands in WAIT_DATA,
    // hence pop_en/pop_mod decode state plus live FIFO flags.
    always_comb begin
        fifo_pop_en  = 1'b0;
        fifo_pop_mod = POP_16;
        if (state == POP) begin
            fifo_pop_en  = can_pair || can_single;
            fifo_pop_mod = can_pair ? POP_32 : POP_16;
        end
    end

    always_comb begin
        busy      = (state == POP) || (state == WAIT_DATA) || (state == WRITE);
        done      = (state == DONE);
        glb_we    = (state == WRITE);
        glb_addr  = glb_we ? addr : '0;
        glb_wdata = glb_we ? wbuf : '0;
        glb_wmask = glb_we ? (pair ? WMASK_FULL : WMASK_LOW) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= '0;
            addr  <= '0;
            wbuf  <= '0;
            pair  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (psum_cnt != '0) begin
                            rem   <= psum_cnt;
                            addr  <= base_addr;
                            state <= POP;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                POP: begin
                    if (can_pair) begin
                        pair  <= 1'b1;
                        state <= WAIT_DATA;
                    end else if (can_single) begin
                        pair  <= 1'b0;
                        state <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (pair) begin
                        wbuf <= fifo_pop_data;
                    end else begin
                        wbuf <= {{DATA_W{1'b0}}, fifo_pop_data[DATA_W-1:0]};
                    end
                    state <= WRITE;
                end
                WRITE: begin
                    if (glb_ready) begin
                        addr  <= addr + ADDR_W'(4);
                        rem   <= rem_next;
                        state <= (rem_next == '0) ? DONE : POP;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
